pipeline_hazard_controller: RTL and testbench
=============================================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: CLK input 1 (rising edge), RESET input 1 (synchronous, active-high).
REQ-002 SHALL have inputs ID_RS1_ADDR 5 and ID_RS2_ADDR 5, the source registers of the instruction in ID.
REQ-003 SHALL have inputs ID_USES_RS1 1 and ID_USES_RS2 1, which qualify the source registers.
REQ-004 SHALL have inputs EX_MEM_READ 1 and EX_RD_ADDR 5, a load in EX and its destination register.
REQ-005 SHALL have input BRANCH_TAKEN 1, a taken branch/jump resolved in EX.
REQ-006 SHALL have inputs IMEM_BUSYWAIT 1 and DMEM_BUSYWAIT 1, the memory stall requests.
REQ-007 SHALL have outputs PC_HOLD 1, IF_ID_HOLD 1 and PIPE_HOLD 1; PIPE_HOLD freezes the ID/EX, EX/MEM and MEM/WB registers.
REQ-008 SHALL have outputs IF_ID_FLUSH 1 and ID_EX_FLUSH 1, which insert a bubble at the next edge.
REQ-009 SHALL have outputs LU_STALL_CNT 16, FLUSH_CNT 16 and MEM_WAIT_CNT 16, the performance counters.

Function
REQ-010 SHALL implement a registered FSM with states INIT, RUN and FLUSH_PEND; all outputs are Mealy and combinational from state plus inputs (zero-cycle latency).
REQ-011 INIT SHALL last exactly 2 cycles after RESET deasserts, using a 1-bit drain counter; outputs: PC_HOLD=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1, other holds 0; then RUN.
REQ-012 In RUN/FLUSH_PEND, priority 1 is DMEM_BUSYWAIT=1: PC_HOLD=IF_ID_HOLD=PIPE_HOLD=1, both flushes 0, state unchanged, BRANCH_TAKEN ignored that cycle.
REQ-013 RUN priority 2 is BRANCH_TAKEN=1: IF_ID_FLUSH=ID_EX_FLUSH=1, all holds 0 (PC loads target); if IMEM_BUSYWAIT=1 the next state is FLUSH_PEND, else RUN.
REQ-014 RUN priority 3 is load-use: EX_MEM_READ && EX_RD_ADDR!=0 && ((ID_USES_RS1 && ID_RS1_ADDR==EX_RD_ADDR) || (ID_USES_RS2 && ID_RS2_ADDR==EX_RD_ADDR)) gives PC_HOLD=IF_ID_HOLD=1, ID_EX_FLUSH=1, PIPE_HOLD=0 for exactly that cycle.
REQ-015 RUN priority 4 is IMEM_BUSYWAIT=1: PC_HOLD=1, IF_ID_FLUSH=1, IF_ID_HOLD=0, PIPE_HOLD=0, so downstream drains.
REQ-016 RUN with no condition SHALL drive all outputs to 0.
REQ-017 In FLUSH_PEND without DMEM stall: PC_HOLD=1, IF_ID_FLUSH=1, others 0; when IMEM_BUSYWAIT=0, IF_ID_FLUSH=1 still (wrong-path fetch discarded) and the next state is RUN.
REQ-018 The load-use check SHALL be inactive in FLUSH_PEND (ID holds a bubble).
REQ-019 HOLD and FLUSH SHALL never both assert for the same register in one cycle; this is an assertion-checkable invariant.
REQ-020 Register x0 SHALL never cause a load-use stall.

Reset
REQ-021 With RESET=1 at an edge: state becomes INIT, drain counter 0, counters 0.
REQ-022 While RESET=1: PC_HOLD=1, IF_ID_FLUSH=ID_EX_FLUSH=1, IF_ID_HOLD=PIPE_HOLD=0.
REQ-023 RESET asserted mid-FLUSH_PEND or mid-stall SHALL abandon the pending flush and restart INIT.

Configuration
REQ-024 Macro HAZARD_PERF_CNT_EN: when defined, three 16-bit saturating counters are included (hold at 0xFFFF, no wrap).
REQ-025 Counting (with HAZARD_PERF_CNT_EN): LU_STALL_CNT +1 per REQ-014 cycle; FLUSH_CNT +1 per accepted BRANCH_TAKEN; MEM_WAIT_CNT +1 per cycle with DMEM_BUSYWAIT or IMEM_BUSYWAIT.
REQ-026 Without HAZARD_PERF_CNT_EN: ports remain, driven constant 0, no counter flops.

Structure
REQ-027 Package hazard_ctrl_pkg SHALL hold the state encoding (INIT=2'd0, RUN=2'd1, FLUSH_PEND=2'd2), REG_ADDR_W=5, PERF_CNT_W=16 and INIT_DRAIN_CYCLES=2.
REQ-028 The combinational sub-module load_use_detector SHALL compute REQ-014/REQ-020; FSM and counters stay in the top module.

Verification
REQ-029 Load-use: EX_MEM_READ=1, EX_RD_ADDR=5, ID_RS2_ADDR=5, ID_USES_RS2=1 -> 1 cycle PC_HOLD=IF_ID_HOLD=ID_EX_FLUSH=1; same with EX_RD_ADDR=0 -> no stall.
REQ-030 Branch with IMEM miss: BRANCH_TAKEN=1, IMEM_BUSYWAIT=1 for 3 cycles -> both flushes in cycle 0, FLUSH_PEND for 3 cycles with IF_ID_FLUSH=1, RUN after.
REQ-031 Simultaneous: DMEM_BUSYWAIT=1 with BRANCH_TAKEN=1 and a load-use hazard -> full freeze only; branch acted on in the first cycle DMEM_BUSYWAIT=0.
REQ-032 Reset: RESET asserted in FLUSH_PEND -> INIT next edge; exactly 2 INIT cycles after release; counters 0.
REQ-033 Saturation (with HAZARD_PERF_CNT_EN): 65540 load-use cycles -> LU_STALL_CNT=0xFFFF; without the macro all counters read 0.
REQ-034 Invariant: random stimulus for 10k cycles -> REQ-019 is never violated.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and widths for the pipeline hazard controller.
// Latency: n/a (declarations only). Backpressure: n/a.
// Saturating increment helper used by the optional perf counters.
package hazard_ctrl_pkg;

    localparam int REG_ADDR_W        = 5;
    localparam int PERF_CNT_W        = 16;
    localparam int INIT_DRAIN_CYCLES = 2;

    localparam logic [1:0] ST_INIT       = 2'd0;
    localparam logic [1:0] ST_RUN        = 2'd1;
    localparam logic [1:0] ST_FLUSH_PEND = 2'd2;

    typedef struct packed {
        logic pc_hold;
        logic if_id_hold;
        logic pipe_hold;
        logic if_id_flush;
        logic id_ex_flush;
    } hazard_ctl_t;

    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/load_use_detector.sv
// Flags an ID instruction that reads the destination of a load currently in EX.
// Latency: combinational. Backpressure: none; the FSM decides whether the flag is acted on.
// x0 is hardwired zero, so it can never carry a pending load result.
module load_use_detector
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic                  uses_rs1,
    input  logic                  uses_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  hazard
);

    assign hazard = ex_mem_read && (ex_rd_addr != '0) &&
                    ((uses_rs1 && (rs1_addr == ex_rd_addr)) ||
                     (uses_rs2 && (rs2_addr == ex_rd_addr)));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hold/flush control for a 5-stage pipeline; optional perf counters under HAZARD_PERF_CNT_EN.
// Latency: zero-cycle Mealy outputs from state plus inputs; counters update at the next edge.
// Backpressure: DMEM stall freezes everything; IMEM stall holds PC and drains downstream.
module pipeline_hazard_controller
    import hazard_ctrl_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [REG_ADDR_W-1:0] ID_RS1_ADDR,
    input  logic [REG_ADDR_W-1:0] ID_RS2_ADDR,
    input  logic                  ID_USES_RS1,
    input  logic                  ID_USES_RS2,
    input  logic                  EX_MEM_READ,
    input  logic [REG_ADDR_W-1:0] EX_RD_ADDR,
    input  logic                  BRANCH_TAKEN,
    input  logic                  IMEM_BUSYWAIT,
    input  logic                  DMEM_BUSYWAIT,
    output logic                  PC_HOLD,
    output logic                  IF_ID_HOLD,
    output logic                  PIPE_HOLD,
    output logic                  IF_ID_FLUSH,
    output logic                  ID_EX_FLUSH,
    output logic [PERF_CNT_W-1:0] LU_STALL_CNT,
    output logic [PERF_CNT_W-1:0] FLUSH_CNT,
    output logic [PERF_CNT_W-1:0] MEM_WAIT_CNT
);

    localparam hazard_ctl_t CTL_INIT   = '{pc_hold: 1'b1, if_id_hold: 1'b0, pipe_hold: 1'b0,
                                           if_id_flush: 1'b1, id_ex_flush: 1'b1};
    localparam hazard_ctl_t CTL_FREEZE = '{pc_hold: 1'b1, if_id_hold: 1'b1, pipe_hold: 1'b1,
                                           if_id_flush: 1'b0, id_ex_flush: 1'b0};

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        drain_cnt;
    logic        lu_hazard;
    hazard_ctl_t ctl;

    load_use_detector u_lud (
        .rs1_addr    (ID_RS1_ADDR),
        .rs2_addr    (ID_RS2_ADDR),
        .uses_rs1    (ID_USES_RS1),
        .uses_rs2    (ID_USES_RS2),
        .ex_mem_read (EX_MEM_READ),
        .ex_rd_addr  (EX_RD_ADDR),
        .hazard      (lu_hazard)
    );

    always_comb begin
        ctl       = '0;
        state_nxt = state;
        if (RESET) begin
            ctl = CTL_INIT;
        end else begin
            case (state)
                ST_INIT: begin
                    ctl = CTL_INIT;
                    if (drain_cnt == 1'(INIT_DRAIN_CYCLES - 1)) state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (DMEM_BUSYWAIT) begin
                        ctl = CTL_FREEZE;
                    end else if (BRANCH_TAKEN) begin
                        ctl.if_id_flush = 1'b1;
                        ctl.id_ex_flush = 1'b1;
                        state_nxt = IMEM_BUSYWAIT ? ST_FLUSH_PEND : ST_RUN;
                    end else if (lu_hazard) begin
                        ctl.pc_hold     = 1'b1;
                        ctl.if_id_hold  = 1'b1;
                        ctl.id_ex_flush = 1'b1;
                    end else if (IMEM_BUSYWAIT) begin
                        ctl.pc_hold     = 1'b1;
                        ctl.if_id_flush = 1'b1;
                    end
                end
                ST_FLUSH_PEND: begin
                    // The fetch in flight is wrong-path; discard it even on the cycle it returns.
                    if (DMEM_BUSYWAIT) begin
                        ctl = CTL_FREEZE;
                    end else begin
                        ctl.pc_hold     = 1'b1;
                        ctl.if_id_flush = 1'b1;
                        if (!IMEM_BUSYWAIT) state_nxt = ST_RUN;
                    end
                end
                default: begin
                    ctl       = CTL_INIT;
                    state_nxt = ST_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_INIT;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == ST_INIT) ? ~drain_cnt : 1'b0;
        end
    end

    assign PC_HOLD     = ctl.pc_hold;
    assign IF_ID_HOLD  = ctl.if_id_hold;
    assign PIPE_HOLD   = ctl.pipe_hold;
    assign IF_ID_FLUSH = ctl.if_id_flush;
    assign ID_EX_FLUSH = ctl.id_ex_flush;

`ifdef HAZARD_PERF_CNT_EN
    logic lu_acc;
    logic branch_acc;

    assign lu_acc     = !RESET && (state == ST_RUN) && !DMEM_BUSYWAIT && !BRANCH_TAKEN && lu_hazard;
    assign branch_acc = !RESET && (state == ST_RUN) && !DMEM_BUSYWAIT && BRANCH_TAKEN;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            LU_STALL_CNT <= '0;
            FLUSH_CNT    <= '0;
            MEM_WAIT_CNT <= '0;
        end else begin
            if (lu_acc)                          LU_STALL_CNT <= sat_inc(LU_STALL_CNT);
            if (branch_acc)                      FLUSH_CNT    <= sat_inc(FLUSH_CNT);
            if (DMEM_BUSYWAIT || IMEM_BUSYWAIT)  MEM_WAIT_CNT <= sat_inc(MEM_WAIT_CNT);
        end
    end
`else
    assign LU_STALL_CNT = '0;
    assign FLUSH_CNT    = '0;
    assign MEM_WAIT_CNT = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed and random stimulus against a behavioural hazard-control model, checked every cycle.
// Literal expectations on selected cycles pin the model; counters are checked per build option.
module tb_pipeline_hazard_controller;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [4:0]  ID_RS1_ADDR = '0, ID_RS2_ADDR = '0, EX_RD_ADDR = '0;
    logic        ID_USES_RS1 = 1'b0, ID_USES_RS2 = 1'b0, EX_MEM_READ = 1'b0;
    logic        BRANCH_TAKEN = 1'b0, IMEM_BUSYWAIT = 1'b0, DMEM_BUSYWAIT = 1'b0;
    logic        PC_HOLD, IF_ID_HOLD, PIPE_HOLD, IF_ID_FLUSH, ID_EX_FLUSH;
    logic [15:0] LU_STALL_CNT, FLUSH_CNT, MEM_WAIT_CNT;

    int vectors = 0;
    int miscompares = 0;

    // Model state: remaining init cycles, pending wrong-path discard, event counts.
    int m_init_left = 2;
    bit m_pend = 1'b0;
    int m_lu = 0, m_fl = 0, m_mw = 0;

    bit          lit_chk = 1'b0;
    logic [4:0]  lit_exp = '0;
    string       lit_name = "";
    bit          lit_cnt_chk = 1'b0;
    logic [47:0] lit_cnt_exp = '0;

    pipeline_hazard_controller dut (
        .CLK(CLK), .RESET(RESET),
        .ID_RS1_ADDR(ID_RS1_ADDR), .ID_RS2_ADDR(ID_RS2_ADDR),
        .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
        .EX_MEM_READ(EX_MEM_READ), .EX_RD_ADDR(EX_RD_ADDR),
        .BRANCH_TAKEN(BRANCH_TAKEN), .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .DMEM_BUSYWAIT(DMEM_BUSYWAIT),
        .PC_HOLD(PC_HOLD), .IF_ID_HOLD(IF_ID_HOLD), .PIPE_HOLD(PIPE_HOLD),
        .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_FLUSH(ID_EX_FLUSH),
        .LU_STALL_CNT(LU_STALL_CNT), .FLUSH_CNT(FLUSH_CNT), .MEM_WAIT_CNT(MEM_WAIT_CNT)
    );

    initial forever #5 CLK = ~CLK;

    // Output order: {pc_hold, if_id_hold, pipe_hold, if_id_flush, id_ex_flush}.
    function automatic void model_eval(output logic [4:0] o, output int nl, output bit np,
                                       output bit li, output bit fi, output bit mi);
        bit hz;
        hz = EX_MEM_READ && (EX_RD_ADDR != 0) &&
             ((ID_USES_RS1 && ID_RS1_ADDR == EX_RD_ADDR) || (ID_USES_RS2 && ID_RS2_ADDR == EX_RD_ADDR));
        o = 5'b00000; nl = m_init_left; np = m_pend; li = 1'b0; fi = 1'b0; mi = 1'b0;
        if (RESET) begin
            o = 5'b10011; nl = 2; np = 1'b0;
        end else begin
            mi = DMEM_BUSYWAIT || IMEM_BUSYWAIT;
            if (m_init_left > 0) begin
                o = 5'b10011; nl = m_init_left - 1;
            end else if (DMEM_BUSYWAIT) begin
                o = 5'b11100;
            end else if (m_pend) begin
                o = 5'b10010; np = IMEM_BUSYWAIT;
            end else if (BRANCH_TAKEN) begin
                o = 5'b00011; np = IMEM_BUSYWAIT; fi = 1'b1;
            end else if (hz) begin
                o = 5'b11001; li = 1'b1;
            end else if (IMEM_BUSYWAIT) begin
                o = 5'b10010;
            end
        end
    endfunction

    always @(posedge CLK) begin
        logic [4:0] o; int nl; bit np, li, fi, mi;
        model_eval(o, nl, np, li, fi, mi);
        m_init_left <= nl;
        m_pend      <= np;
        m_lu <= RESET ? 0 : ((li && m_lu < 65535) ? m_lu + 1 : m_lu);
        m_fl <= RESET ? 0 : ((fi && m_fl < 65535) ? m_fl + 1 : m_fl);
        m_mw <= RESET ? 0 : ((mi && m_mw < 65535) ? m_mw + 1 : m_mw);
    end

    always @(negedge CLK) begin
        logic [4:0] o, got; int nl; bit np, li, fi, mi;
        logic [47:0] cnt_exp, cnt_got;
        model_eval(o, nl, np, li, fi, mi);
        got     = {PC_HOLD, IF_ID_HOLD, PIPE_HOLD, IF_ID_FLUSH, ID_EX_FLUSH};
        cnt_got = {LU_STALL_CNT, FLUSH_CNT, MEM_WAIT_CNT};
`ifdef HAZARD_PERF_CNT_EN
        cnt_exp = {16'(m_lu), 16'(m_fl), 16'(m_mw)};
`else
        cnt_exp = '0;
`endif
        vectors++;
        if (got !== o) begin
            miscompares++;
            $display("FAIL ctl t=%0t got=%b expected=%b", $time, got, o);
        end
        if (cnt_got !== cnt_exp) begin
            miscompares++;
            $display("FAIL counters t=%0t got=%h expected=%h", $time, cnt_got, cnt_exp);
        end
        if ((IF_ID_HOLD && IF_ID_FLUSH) || (PIPE_HOLD && ID_EX_FLUSH)) begin
            miscompares++;
            $display("FAIL hold_flush_overlap t=%0t got=%b expected no overlap", $time, got);
        end
        if (lit_chk && got !== lit_exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%b expected=%b", lit_name, $time, got, lit_exp);
        end
        if (lit_cnt_chk && cnt_got !== lit_cnt_exp) begin
            miscompares++;
            $display("FAIL %s_cnt t=%0t got=%h expected=%h", lit_name, $time, cnt_got, lit_cnt_exp);
        end
    end

    task automatic drive(input bit rst, input bit dm, input bit im, input bit br,
                         input bit mr, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input bit u1, input bit u2,
                         input bit chk, input logic [4:0] exp, input string nm);
        @(posedge CLK);
        #1;
        RESET = rst; DMEM_BUSYWAIT = dm; IMEM_BUSYWAIT = im; BRANCH_TAKEN = br;
        EX_MEM_READ = mr; EX_RD_ADDR = rd; ID_RS1_ADDR = rs1; ID_RS2_ADDR = rs2;
        ID_USES_RS1 = u1; ID_USES_RS2 = u2;
        lit_chk = chk; lit_exp = exp; lit_name = nm; lit_cnt_chk = 1'b0;
    endtask

    task automatic idle(input bit chk, input string nm);
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, chk, 5'b00000, nm);
    endtask

    initial begin
        // Reset and the two-cycle init drain
        drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 5'b10011, "reset");
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 5'b10011, "init0");
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 5'b10011, "init1");
        idle(1, "run_idle");
        // Load-use
        drive(0, 0, 0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 1, 1, 5'b11001, "lu_rs2");
        drive(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 1, 1, 5'b00000, "lu_x0");
        drive(0, 0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 0, 0, 1, 5'b00000, "lu_unused");
        drive(0, 0, 0, 0, 1, 5'd3, 5'd3, 5'd0, 1, 0, 1, 5'b11001, "lu_rs1");
        // Branch with IMEM miss
        drive(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 5'b00011, "br_c0");
        drive(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 5'b10010, "fp1");
        drive(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 5'b10010, "fp2");
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 5'b10010, "fp3");
        idle(1, "br_run");
        // DMEM stall with branch and load-use pending
        drive(0, 1, 0, 1, 1, 5'd7, 5'd7, 5'd0, 1, 0, 1, 5'b11100, "sim_frz0");
        drive(0, 1, 0, 1, 1, 5'd7, 5'd7, 5'd0, 1, 0, 1, 5'b11100, "sim_frz1");
        drive(0, 0, 0, 1, 1, 5'd7, 5'd7, 5'd0, 1, 0, 1, 5'b00011, "sim_br");
        idle(1, "sim_run");
        drive(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 5'b10010, "imem_only");
        drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 5'b11100, "dmem_only");
        // Reset in the middle of a pending flush
        drive(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 5'b00011, "rbr_c0");
        drive(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 5'b10010, "rbr_fp");
        drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 5'b10011, "rst_fp");
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 5'b10011, "rst_init0");
        lit_cnt_chk = 1'b1; lit_cnt_exp = '0;
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 5'b10011, "rst_init1");
        idle(1, "rst_run");
        // Random soak
        for (int i = 0; i < 10000; i++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 5'b00000, "rand");
        end
        // Load-use counter run
        drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 5'b10011, "sat_rst");
        idle(0, "sat_init0");
        idle(0, "sat_init1");
`ifdef HAZARD_PERF_CNT_EN
        for (int i = 0; i < 65540; i++)
            drive(0, 0, 0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 5'b00000, "sat_lu");
        idle(1, "sat_end");
        lit_cnt_chk = 1'b1; lit_cnt_exp = {16'hFFFF, 16'h0000, 16'h0000};
`else
        for (int i = 0; i < 20; i++)
            drive(0, 0, 0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 5'b00000, "nocnt_lu");
        idle(1, "nocnt_end");
        lit_cnt_chk = 1'b1; lit_cnt_exp = '0;
`endif
        @(posedge CLK);
        #1;
        lit_chk = 1'b0; lit_cnt_chk = 1'b0;
        @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
